// File: rtl/riscv_pkg.sv
// Shared RV64 definitions: memory access codes from ControlUnit, LSU state
// encoding and byte-mask helpers used by the load/store path.
package riscv_pkg;

  localparam logic [2:0] MR_NONE = 3'd0;
  localparam logic [2:0] MR_LB   = 3'd1;
  localparam logic [2:0] MR_LH   = 3'd2;
  localparam logic [2:0] MR_LW   = 3'd3;
  localparam logic [2:0] MR_LD   = 3'd4;
  localparam logic [2:0] MR_LBU  = 3'd5;
  localparam logic [2:0] MR_LHU  = 3'd6;
  localparam logic [2:0] MR_LWU  = 3'd7;

  localparam logic [2:0] MW_NONE = 3'd0;
  localparam logic [2:0] MW_SB   = 3'd1;
  localparam logic [2:0] MW_SH   = 3'd2;
  localparam logic [2:0] MW_SW   = 3'd3;
  localparam logic [2:0] MW_SD   = 3'd4;

  // Access size is log2 of the byte count: 0 B, 1 H, 2 W, 3 D.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP,
    ST_FAULT
  } lsu_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] read_size(input logic [2:0] code);
    logic [1:0] s;
    case (code)
      MR_LB, MR_LBU: s = SZ_B;
      MR_LH, MR_LHU: s = SZ_H;
      MR_LW, MR_LWU: s = SZ_W;
      default:       s = SZ_D;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] write_size(input logic [2:0] code);
    logic [1:0] s;
    case (code)
      MW_SB:   s = SZ_B;
      MW_SH:   s = SZ_H;
      MW_SW:   s = SZ_W;
      default: s = SZ_D;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment between a naturally aligned access and the doubleword
// data bus: store lane shift/strobes and load extract/extension.
module mem_align
  import riscv_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [2:0]  offset_i,
  input  logic        unsigned_i,
  input  logic [63:0] store_data_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  wstrb_o,
  output logic [63:0] load_data_o
);

  logic [63:0] rshift;

  assign wdata_o = store_data_i << {offset_i, 3'b000};
  assign wstrb_o = size_mask(size_i) << offset_i;
  assign rshift  = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    load_data_o = rshift;
    case (size_i)
      SZ_B: load_data_o = unsigned_i ? {56'd0, rshift[7:0]}
                                     : {{56{rshift[7]}}, rshift[7:0]};
      SZ_H: load_data_o = unsigned_i ? {48'd0, rshift[15:0]}
                                     : {{48{rshift[15]}}, rshift[15:0]};
      SZ_W: load_data_o = unsigned_i ? {32'd0, rshift[31:0]}
                                     : {{32{rshift[31]}}, rshift[31:0]};
      default: load_data_o = rshift;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV64 memory-access stage: one outstanding aligned doubleword transaction
// over req/gnt/rvalid, with misaligned/illegal accesses reported as faults.
//
// state    | meaning
// IDLE     | ready to accept an op from execute
// REQ      | dmem_req held until dmem_gnt
// WAIT     | load granted, waiting for dmem_rvalid
// RESP     | one-cycle completion pulse to writeback
// FAULT    | one-cycle fault pulse, memory untouched
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      mem_read,
  input  logic [2:0]      mem_write,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wstrb,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            out_valid,
  output logic            out_reg_write,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr
);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;

  logic            is_load, is_store, illegal, misaligned;
  logic [1:0]      req_size;
  logic [XLEN-1:0] wdata, load_data;
  logic [7:0]      wstrb;

  mem_align u_align (
    .size_i       (size_q),
    .offset_i     (addr_q[2:0]),
    .unsigned_i   (uns_q),
    .store_data_i (sdata_q),
    .rdata_i      (dmem_rdata),
    .wdata_o      (wdata),
    .wstrb_o      (wstrb),
    .load_data_o  (load_data)
  );

  always_comb begin
    is_load  = (mem_read != MR_NONE);
    is_store = (mem_write != MW_NONE);
    req_size = is_store ? write_size(mem_write) : read_size(mem_read);
    illegal  = (is_load && is_store) || (mem_write > MW_SD);
    case (req_size)
      SZ_H:    misaligned = addr[0];
      SZ_W:    misaligned = |addr[1:0];
      SZ_D:    misaligned = |addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    sdata_d      = sdata_q;
    rd_d         = rd_q;
    data_d       = data_q;
    fault_addr_d = fault_addr_q;
    case (state_q)
      ST_IDLE: begin
        // Ops with both codes zero are swallowed without leaving IDLE.
        if (in_valid && (is_load || is_store)) begin
          if (illegal || misaligned) begin
            state_d      = ST_FAULT;
            fault_addr_d = addr;
          end else begin
            state_d = ST_REQ;
            we_d    = is_store;
            size_d  = req_size;
            uns_d   = (mem_read >= MR_LBU);
            addr_d  = addr;
            sdata_d = store_data;
            rd_d    = rd;
            data_d  = '0;
          end
        end
      end
      ST_REQ:   if (dmem_gnt) state_d = we_q ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (dmem_rvalid) begin
          data_d  = load_data;
          state_d = ST_RESP;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      sdata_q      <= '0;
      rd_q         <= '0;
      data_q       <= '0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      sdata_q      <= sdata_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign dmem_req      = (state_q == ST_REQ);
  assign dmem_we       = dmem_req && we_q;
  assign dmem_addr     = {addr_q[XLEN-1:3], 3'b000};
  assign dmem_wdata    = wdata;
  assign dmem_wstrb    = dmem_we ? wstrb : 8'h00;
  assign out_valid     = (state_q == ST_RESP);
  assign out_reg_write = out_valid && !we_q;
  assign out_rd        = out_valid ? rd_q : 5'd0;
  assign out_data      = out_valid ? data_q : '0;
  assign fault         = (state_q == ST_FAULT);
  assign fault_addr    = fault_addr_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RV64 core: consumes the `MemRead`/`MemWrite` size codes produced by `ControlUnit` (carried through the execute stage), issues aligned doubleword requests to data memory over a req/gnt/rvalid handshake, and returns sign- or zero-extended load data to writeback. It stalls upstream while a memory transaction is outstanding and flags misaligned or illegal accesses without touching memory.

## Interface
Parameters:
- `XLEN`, 64: data/address width; only 64 is supported.

Ports:
- `clk` in 1: the block's single clock; every register updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: execute stage presents an op.
- `in_ready` out 1: LSU can accept; high only in IDLE.
- `mem_read` in 3: load code; 0 none, 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU.
- `mem_write` in 3: store code; 0 none, 1 SB, 2 SH, 3 SW, 4 SD, 5–7 illegal.
- `addr` in 64: effective address from the ALU.
- `store_data` in 64: rs2 value; low bytes are used.
- `rd` in 5: destination register tag.
- `dmem_req` out 1: memory request, held until `dmem_gnt`.
- `dmem_we` out 1: 1 store, 0 load.
- `dmem_addr` out 64: `{addr[63:3], 3'b000}`.
- `dmem_wdata` out 64: store data shifted into its byte lanes.
- `dmem_wstrb` out 8: byte enables; 0 for loads.
- `dmem_gnt` in 1: request accepted this cycle.
- `dmem_rvalid` in 1: read data valid.
- `dmem_rdata` in 64: read doubleword.
- `out_valid` out 1: one-cycle completion pulse.
- `out_reg_write` out 1: completion is a load and writes `out_rd`.
- `out_rd` out 5: destination tag.
- `out_data` out 64: extended load data; 0 for stores.
- `fault` out 1: one-cycle pulse for a misaligned or illegal access.
- `fault_addr` out 64: offending address; holds until the next fault.

## Operation
- Accept on `in_valid && in_ready`; latch codes, `addr`, `store_data` and `rd`. `offset` = `addr[2:0]`.
- `mem_read == 0 && mem_write == 0`: no-op; accepted, remains in IDLE, no output.
- Both codes nonzero, or `mem_write` ≥ 5: illegal.
- Misaligned: H with `offset[0]`, W with `offset[1:0]` != 0, or D with `offset` != 0.
- Illegal or misaligned: go to FAULT; `fault` pulses; `fault_addr` = `addr`; no `dmem_req` is issued.
- Store lanes: `dmem_wstrb` = size mask (`0x01`/`0x03`/`0x0F`/`0xFF`) << `offset`; `dmem_wdata` = `store_data` << (8·`offset`).
- Load extract: `dmem_rdata` >> (8·`offset`), truncated to the access size, then sign-extended (B/H/W) or zero-extended (BU/HU/WU). D passes through unchanged.
- States and transitions:
  - IDLE: valid memory op → REQ; fault → FAULT.
  - REQ: `dmem_req` = 1; on `dmem_gnt`, store → RESP, load → WAIT.
  - WAIT: on `dmem_rvalid`, capture the extracted data → RESP.
  - RESP: `out_valid` = 1 → IDLE.
  - FAULT: `fault` = 1 → IDLE.
- `dmem_rvalid` outside WAIT is ignored. `dmem_gnt` outside REQ is ignored.

## Timing
- Reset values: `in_ready` = 1; all other outputs = 0, including `fault_addr`. State = IDLE. Reset mid-transaction abandons it; a late `rvalid` is ignored.
- Accept in cycle 0 → `dmem_req` asserted from cycle 1. `dmem_addr`, `dmem_we`, `dmem_wdata` and `dmem_wstrb` stay stable until the `gnt` cycle inclusive.
- Store with `gnt` in cycle 1 → `out_valid` in cycle 2.
- Load with `gnt` in cycle 1 and `rvalid` in cycle k ≥ 2 → `out_valid` in cycle k+1.
- `rvalid` in the same cycle as `gnt` is not supported; the memory returns data at least one cycle after `gnt`.
- Fault: accept in cycle 0 → `fault` in cycle 1.
- `in_ready` returns high in the cycle after RESP or FAULT. Best-case throughput is one memory op per 3 cycles (store) or 4 cycles (load).
- All outputs are registered or decoded from the state register; there is no combinational path from the `in_*` inputs to the `dmem_*` outputs.

## Structure
- Shared package `riscv_pkg`:
  - `MemRead`/`MemWrite` code constants, shared with `ControlUnit`.
  - LSU state enum.
  - Size-mask function.
- Sub-module `mem_align` (combinational):
  - Store side: lane shift plus strobe generation.
  - Load side: extract plus extension.
  - Instantiated once by `load_store_unit`.

## Test plan
- LW at 0x1004, `rdata` 0x80000001_DEADBEEF → `out_data` 0xFFFFFFFF_80000001, `out_reg_write` = 1. Same access as LWU → 0x00000000_80000001.
- SB at 0x1003, `store_data` 0x...AB → `dmem_addr` 0x1000, `wstrb` 0x08, `wdata[31:24]` = 0xAB, `dmem_we` = 1; `out_valid` one cycle after `gnt`, `out_reg_write` = 0.
- LH at 0x1001 → `fault` pulse in cycle 1, `fault_addr` 0x1001, `dmem_req` never asserted. Same check for `mem_read` = 2 with `mem_write` = 1 (illegal).
- SD at 0x2000 with `gnt` delayed 3 cycles → `dmem_req` and all `dmem_*` outputs stable for 4 cycles; `in_ready` low throughout; `wstrb` 0xFF.
- LB at 0x3007, `rdata[63:56]` = 0x80 → `out_data` 0xFFFFFFFF_FFFFFF80. Same access as LBU → 0x80.
- `rst_n` pulsed low in WAIT, then `rvalid` → all outputs 0, `in_ready` = 1, no `out_valid`.
